// File: rtl/alu_host_sequencer.sv
// Host-side sequencer for the 8-bit sequential ALU: request -> start/X/Y pin sequence -> wait -> response.
// Optional statistics counters are enabled by defining ALU_HOST_STATS_EN.
module alu_host_sequencer #(
    parameter logic [3:0] IDLE_STATE = 4'd0,
    parameter int         TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic [1:0]  alu_op,
    output logic        alu_start,
    output logic [7:0]  alu_inbus,
    input  logic [15:0] alu_outbus,
    input  logic [3:0]  alu_state
`ifdef ALU_HOST_STATS_EN
    ,
    output logic [15:0] txn_count,
    output logic [7:0]  timeout_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_X,
        S_LOAD_Y,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        left_idle_q, left_idle_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        alu_start_q, alu_start_d;
    logic [7:0]  alu_inbus_q, alu_inbus_d;

    // Outputs are registered from the next state, so each pin value lines up with the state it belongs to.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (which would infer a latch).
        state_d       = state_q;
        op_d          = op_q;
        x_d           = x_q;
        y_d           = y_q;
        cnt_d         = cnt_q;
        left_idle_d   = left_idle_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    x_d     = req_x;
                    y_d     = req_y;
                    state_d = S_START;
                end
            end
            S_START:  state_d = S_LOAD_X;
            S_LOAD_X: state_d = S_LOAD_Y;
            S_LOAD_Y: begin
                cnt_d       = 8'd0;
                left_idle_d = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (alu_state != IDLE_STATE) begin
                    left_idle_d = 1'b1;
                end
                // Completion is checked first so it wins over a coincident timeout.
                if (left_idle_q && (alu_state == IDLE_STATE)) begin
                    rsp_data_d    = alu_outbus;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = 16'h0000;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        alu_start_d = (state_d == S_START);
        alu_op_d    = (state_d inside {S_START, S_LOAD_X, S_LOAD_Y, S_WAIT}) ? op_d : 2'b00;
        case (state_d)
            S_LOAD_X: alu_inbus_d = x_d;
            S_LOAD_Y: alu_inbus_d = y_d;
            default:  alu_inbus_d = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= 2'b00;
            x_q           <= 8'h00;
            y_q           <= 8'h00;
            cnt_q         <= 8'd0;
            left_idle_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 16'h0000;
            rsp_timeout_q <= 1'b0;
            alu_op_q      <= 2'b00;
            alu_start_q   <= 1'b0;
            alu_inbus_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            left_idle_q   <= left_idle_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            alu_op_q      <= alu_op_d;
            alu_start_q   <= alu_start_d;
            alu_inbus_q   <= alu_inbus_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign alu_op      = alu_op_q;
    assign alu_start   = alu_start_q;
    assign alu_inbus   = alu_inbus_q;

`ifdef ALU_HOST_STATS_EN
    logic        rsp_hs;
    logic [15:0] txn_count_q;
    logic [7:0]  timeout_count_q;

    assign rsp_hs = (state_q == S_RESP) && rsp_ready;

    // Transactions wrap; timeouts saturate so a stuck ALU stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count_q     <= 16'h0000;
            timeout_count_q <= 8'h00;
        end else if (rsp_hs) begin
            txn_count_q <= txn_count_q + 16'h0001;
            if (rsp_timeout_q && (timeout_count_q != 8'hFF)) begin
                timeout_count_q <= timeout_count_q + 8'h01;
            end
        end
    end

    assign txn_count     = txn_count_q;
    assign timeout_count = timeout_count_q;
`endif

endmodule
